// File: rtl/scs8hd_bist_pkg.sv
// rtl/scs8hd_bist_pkg.sv - shared types and constants for the scs8hd cell BIST
package scs8hd_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } bist_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Expected Y of a2111oi, bit p = pattern p
  function automatic logic [31:0] a2111oi_truth();
    return 32'h0000_0007;
  endfunction

endpackage

// File: rtl/scs8hd_cell_bist_if.sv
// rtl/scs8hd_cell_bist_if.sv - control, result and cell-pin bundle of the cell BIST
interface scs8hd_cell_bist_if #(
  parameter int N_IN = 5
);
  logic                   start;
  logic                   abort;
  logic [(1<<N_IN)-1:0]   truth;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_y;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_fail;
  logic [15:0]            signature;

  modport master (
    output start, abort, truth, dut_y,
    input  dut_in, busy, done, pass, err_cnt, first_fail, signature
  );

  modport slave (
    input  start, abort, truth, dut_y,
    output dut_in, busy, done, pass, err_cnt, first_fail, signature
  );

endinterface

// File: rtl/scs8hd_bist_misr.sv
// rtl/scs8hd_bist_misr.sv - 16-bit Galois MISR with seed load and shift enable
module scs8hd_bist_misr
  import scs8hd_bist_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        seed,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] sig
);

  logic fb;

  assign fb = sig[15] ^ din;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sig <= MISR_SEED;
    end else if (seed) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/scs8hd_cell_bist.sv
// rtl/scs8hd_cell_bist.sv - exhaustive pattern engine for one combinational scs8hd cell
module scs8hd_cell_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                resetb,
  scs8hd_cell_bist_if.slave   bus
);

  localparam int             NPAT      = 1 << N_IN;
  localparam int             CW        = N_IN + 1;
  localparam logic [N_IN:0]  LAST_PAT  = CW'(NPAT - 1);
  localparam logic [N_IN:0]  ERR_MAX   = CW'(NPAT);
  localparam logic [3:0]     WAIT_LOAD = 4'(SETTLE - 1);

  bist_state_e      state, state_nx;
  logic [NPAT-1:0]  truth_q;
  logic [N_IN:0]    pat;
  logic [3:0]       wcnt;
  logic [N_IN:0]    err_int;
  logic [N_IN-1:0]  first_int;
  logic [15:0]      misr_sig;
  logic             start_ok;
  logic             sample_en;
  logic             mismatch;

  assign start_ok  = bus.start && !bus.abort && (state == ST_IDLE || state == ST_DONE);
  assign sample_en = (state == ST_SAMPLE) && !bus.abort;
  assign mismatch  = bus.dut_y != truth_q[pat[N_IN-1:0]];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // APPLY + (SETTLE-1) WAIT cycles + SAMPLE gives SETTLE+1 cycles per pattern
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE,
      ST_DONE:   if (start_ok) state_nx = ST_APPLY;
      ST_APPLY:  state_nx = (SETTLE > 1) ? ST_WAIT : ST_SAMPLE;
      ST_WAIT:   if (wcnt <= 4'd1) state_nx = ST_SAMPLE;
      ST_SAMPLE: state_nx = (pat == LAST_PAT) ? ST_DONE : ST_APPLY;
      default:   state_nx = ST_IDLE;
    endcase
    if (bus.abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      truth_q        <= '0;
      pat            <= '0;
      wcnt           <= '0;
      err_int        <= '0;
      first_int      <= '0;
      bus.dut_in     <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_cnt    <= '0;
      bus.first_fail <= '0;
      bus.signature  <= MISR_SEED;
    end else begin
      bus.busy <= !bus.abort &&
                  (start_ok || state inside {ST_APPLY, ST_WAIT, ST_SAMPLE});
      bus.done <= !bus.abort && !start_ok && state == ST_DONE;
      bus.pass <= !bus.abort && !start_ok && state == ST_DONE && err_int == '0;
      // Result outputs trail the internal accumulators by one cycle
      bus.err_cnt    <= err_int;
      bus.first_fail <= first_int;
      bus.signature  <= misr_sig;

      if (bus.abort) begin
        bus.dut_in <= '0;
      end else if (start_ok) begin
        truth_q   <= bus.truth;
        pat       <= '0;
        err_int   <= '0;
        first_int <= '0;
      end else begin
        case (state)
          ST_APPLY: begin
            bus.dut_in <= pat[N_IN-1:0];
            wcnt       <= WAIT_LOAD;
          end
          ST_WAIT: wcnt <= wcnt - 4'd1;
          ST_SAMPLE: begin
            if (mismatch) begin
              if (err_int != ERR_MAX) err_int <= err_int + 1'b1;
              if (err_int == '0)      first_int <= pat[N_IN-1:0];
            end
            if (pat != LAST_PAT) pat <= pat + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  scs8hd_bist_misr u_misr (
    .clk    (clk),
    .resetb (resetb),
    .seed   (start_ok),
    .shift  (sample_en),
    .din    (bus.dut_y),
    .sig    (misr_sig)
  );

endmodule

// File: doc/scs8hd_cell_bist.md
# scs8hd_cell_bist

Built-in exhaustive test engine for one combinational scs8hd logic cell of up to 8 inputs (5 inputs for the a2111oi/o2111ai family). It drives every input pattern into the cell under test, waits a settle interval, samples the cell output and compares it with an expected truth table. It reports a mismatch count, the first failing pattern and a 16-bit MISR signature. It sits beside the cell in library-characterisation and silicon-debug test structures and is the driver/reader at the other end of the cell's pin interface.

## Interface
- N_IN, 5: number of cell inputs driven (1..8).
- SETTLE, 2: cycles between applying a pattern and sampling Y (1..15).
- CLK  in  1  sole clock, rising edge.
- RESETB  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- ABORT  in  1  stops a run and returns to IDLE; DONE and PASS stay low.
- TRUTH  in  2**N_IN  expected Y for pattern p at bit p; sampled once, on the accepted START.
- DUT_IN  out  N_IN  registered cell inputs; bit0=A1, bit1=A2, bit2=B1, bit3=C1, bit4=D1 for 5-input cells.
- DUT_Y  in  1  cell output.
- BUSY  out  1  high from the cycle after an accepted START until the run ends.
- DONE  out  1  level; high after a completed run until the next accepted START.
- PASS  out  1  valid while DONE; 1 iff ERR_CNT==0.
- ERR_CNT  out  N_IN+1  number of mismatching patterns, saturating at 2**N_IN.
- FIRST_FAIL  out  N_IN  first mismatching pattern index; 0 when ERR_CNT==0.
- SIGNATURE  out  16  MISR over the sampled DUT_Y sequence.

## Operation
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- Reset: FSM goes to IDLE. DUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, SIGNATURE=16'hFFFF.
- Accepted START does the following:
  - latch TRUTH;
  - clear ERR_CNT and FIRST_FAIL;
  - seed SIGNATURE to 16'hFFFF;
  - set pattern counter p=0;
  - go to APPLY.
- APPLY: DUT_IN<=p, go to WAIT. The wait counter loads SETTLE-1.
- WAIT: decrement the counter; at 0, go to SAMPLE.
- SAMPLE:
  - compare DUT_Y with TRUTH_latched[p];
  - on mismatch, increment ERR_CNT, and set FIRST_FAIL=p if this is the first mismatch;
  - shift DUT_Y into the MISR: polynomial x^16+x^12+x^5+1, Galois form, feedback=SIGNATURE[15]^DUT_Y;
  - if p==2**N_IN-1, go to DONE; otherwise p++ and go to APPLY.
- DONE: DONE=1, PASS=(ERR_CNT==0), BUSY=0. DUT_IN holds the last pattern.
- START while BUSY is ignored.
- ABORT has priority over START and over every state transition. It returns the FSM to IDLE, clears BUSY and DUT_IN, and leaves ERR_CNT, FIRST_FAIL and SIGNATURE frozen.
- Pattern counter is N_IN+1 bits. The terminal test uses the full width; there is no wrap-around within a run.

## Timing
- The accepted START edge is cycle 0.
- Pattern p is applied (DUT_IN updates) at cycle 1+p*(SETTLE+1) and sampled SETTLE cycles later.
- DONE rises at cycle 2**N_IN*(SETTLE+1)+1. With defaults this is cycle 97.
- DUT_Y must be stable within SETTLE-1 clock periods of the DUT_IN edge. DUT_Y is not synchronised; the cell is in the CLK domain.
- Outputs are all registered. The result outputs update the cycle after the SAMPLE that produced them.
- Reset mid-run takes effect immediately (asynchronous). Its removal is synchronous to CLK, and the block stays in IDLE.

## Structure
- Package scs8hd_bist_pkg holds:
  - FSM state enum;
  - MISR polynomial constant 16'h1021;
  - MISR seed 16'hFFFF;
  - a function returning the a2111oi truth table (32'h0000_0007) for benches.
- One sub-module, scs8hd_bist_misr: 16-bit MISR with seed load and shift-enable.
- Everything else sits in one FSM module.

## Test plan
- TRUTH=32'h0000_0007 with a behavioural a2111oi model (Y=~((A1&A2)|B1|C1|D1)) on DUT_Y, START. Expect DONE at cycle 97, PASS=1, ERR_CNT=0, FIRST_FAIL=0, and SIGNATURE equal to the scoreboard MISR.
- Same run with DUT_Y stuck at 0. Expect ERR_CNT=3, FIRST_FAIL=0, PASS=0.
- Same run with A2 forced high inside the model. Expect ERR_CNT=1 (pattern 1 mismatches, expected 1, got 0), FIRST_FAIL=1.
- TRUTH=32'h0000_0007 against an inverted model. Expect ERR_CNT=32 (saturated), PASS=0.
- ABORT at cycle 40. Expect BUSY=0 and DUT_IN=0 the next cycle, DONE=0; a START at cycle 50 then runs a full clean pass.
- RESETB low at cycle 20, plus a START pulse during BUSY. Expect all outputs at reset values asynchronously; the START during BUSY does not restart the count.
